// File: rtl/draw_rect_char_20x16_pkg.sv
// Shared widths and helpers for the 20x16 character text-overlay stage.
// Holds the VGA bus widths, the font cell geometry and the char_xy field split.
package draw_rect_char_20x16_pkg;

  localparam int HCNT_W     = 11;
  localparam int RGB_W      = 12;
  localparam int FONT_W     = 8;
  localparam int FONT_H     = 16;
  localparam int CHAR_ROW_W = 4;
  localparam int CHAR_COL_W = 5;
  localparam int CHAR_XY_W  = CHAR_ROW_W + CHAR_COL_W;
  localparam int REL_W      = 8;
  localparam int BIT_W      = 3;
  localparam int LINE_W     = 4;
  localparam int TIMING_W   = 2 * HCNT_W + 4;

  function automatic logic [CHAR_XY_W-1:0] char_addr(
    input logic [CHAR_ROW_W-1:0] row,
    input logic [CHAR_COL_W-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/draw_rect_char_20x16_vga_delay.sv
// Fixed-latency shift register for VGA timing buses.
// Every stage clears to zero on reset so outputs stay quiet until refilled.
module vga_delay #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_r;

  // Shift the bus one stage per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_r <= {(DEPTH*WIDTH){1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/draw_rect_char_20x16.sv
// Text-overlay stage: addresses the char-code/font ROMs from the pixel position and
// paints lit glyph pixels over the RGB stream, keeping timing aligned (3-cycle latency).
module draw_rect_char_20x16
  import draw_rect_char_20x16_pkg::*;
#(
  parameter int               XPOS         = 48,
  parameter int               YPOS         = 48,
  parameter int               COLS         = 20,
  parameter int               ROWS         = 16,
  parameter logic [RGB_W-1:0] LETTER_COLOR = 12'hfff
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [HCNT_W-1:0]    hcount_in,
  input  logic                 hsync_in,
  input  logic                 hblnk_in,
  input  logic [HCNT_W-1:0]    vcount_in,
  input  logic                 vsync_in,
  input  logic                 vblnk_in,
  input  logic [RGB_W-1:0]     rgb_in,
  input  logic [FONT_W-1:0]    char_line_pixels,
  output logic [CHAR_XY_W-1:0] char_xy,
  output logic [LINE_W-1:0]    char_line,
  output logic [HCNT_W-1:0]    hcount_out,
  output logic                 hsync_out,
  output logic                 hblnk_out,
  output logic [HCNT_W-1:0]    vcount_out,
  output logic                 vsync_out,
  output logic                 vblnk_out,
  output logic [RGB_W-1:0]     rgb_out
);

  localparam logic [HCNT_W-1:0] X_LO = HCNT_W'(XPOS);
  localparam logic [HCNT_W-1:0] X_HI = HCNT_W'(XPOS + FONT_W * COLS);
  localparam logic [HCNT_W-1:0] Y_LO = HCNT_W'(YPOS);
  localparam logic [HCNT_W-1:0] Y_HI = HCNT_W'(YPOS + FONT_H * ROWS);
  localparam logic [REL_W-1:0]  X_LO8 = X_LO[REL_W-1:0];
  localparam logic [REL_W-1:0]  Y_LO8 = Y_LO[REL_W-1:0];

  logic              in_area_s;
  logic              draw_en_s;
  logic [REL_W-1:0]  rel_x_s;
  logic [REL_W-1:0]  rel_y_s;
  logic [BIT_W-1:0]  bit_sel_s;
  logic              lit_s;
  logic [TIMING_W-1:0] timing_s;
  logic [TIMING_W-1:0] timing_d3_s;

  logic              draw_en_d1_r, draw_en_d2_r;
  logic [BIT_W-1:0]  bit_d1_r, bit_d2_r;
  logic [RGB_W-1:0]  rgb_d1_r, rgb_d2_r;

  // Area test on the raw counters first, so pixels left of XPOS never wrap into the area.
  always_comb begin
    in_area_s = 1'b0;
    rel_x_s   = 8'd0;
    rel_y_s   = 8'd0;
    draw_en_s = 1'b0;
    in_area_s = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    rel_x_s   = hcount_in[REL_W-1:0] - X_LO8;
    rel_y_s   = vcount_in[REL_W-1:0] - Y_LO8;
    draw_en_s = in_area_s && !hblnk_in && !vblnk_in;
  end

  // Stage 1: ROM addresses plus the locally pipelined overlay controls.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      char_xy      <= 9'd0;
      char_line    <= 4'd0;
      draw_en_d1_r <= 1'b0;
      bit_d1_r     <= 3'd0;
      rgb_d1_r     <= 12'h000;
    end else begin
      if (in_area_s) begin
        char_xy   <= char_addr(rel_y_s[7:4], rel_x_s[7:3]);
        char_line <= rel_y_s[3:0];
      end else begin
        char_xy   <= 9'd0;
        char_line <= 4'd0;
      end
      draw_en_d1_r <= draw_en_s;
      bit_d1_r     <= rel_x_s[2:0];
      rgb_d1_r     <= rgb_in;
    end
  end

  // Stage 2: hold controls while the ROM chain produces the glyph slice.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      draw_en_d2_r <= 1'b0;
      bit_d2_r     <= 3'd0;
      rgb_d2_r     <= 12'h000;
    end else begin
      draw_en_d2_r <= draw_en_d1_r;
      bit_d2_r     <= bit_d1_r;
      rgb_d2_r     <= rgb_d1_r;
    end
  end

  // Column 0 of a cell is the MSB of the glyph slice.
  always_comb begin
    bit_sel_s = 3'd0;
    lit_s     = 1'b0;
    bit_sel_s = 3'd7 - bit_d2_r;
    lit_s     = draw_en_d2_r && char_line_pixels[bit_sel_s];
  end

  // Stage 3: overlay the letter colour on lit pixels.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb_out <= 12'h000;
    end else begin
      rgb_out <= lit_s ? LETTER_COLOR : rgb_d2_r;
    end
  end

  assign timing_s = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

  vga_delay #(
    .WIDTH (TIMING_W),
    .DEPTH (3)
  ) u_timing_delay (
    .clk  (pclk),
    .rst  (rst),
    .din  (timing_s),
    .dout (timing_d3_s)
  );

  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = timing_d3_s;

endmodule

// File: tb/tb_draw_rect_char_20x16.sv
// Scoreboard bench for draw_rect_char_20x16: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them when each pixel reaches the outputs.
module tb_draw_rect_char_20x16;

  localparam int XPOS = 48;
  localparam int YPOS = 48;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic        hsync_in  = 1'b0;
  logic        hblnk_in  = 1'b0;
  logic [10:0] vcount_in = 11'd0;
  logic        vsync_in  = 1'b0;
  logic        vblnk_in  = 1'b0;
  logic [11:0] rgb_in    = 12'h000;
  logic [7:0]  char_line_pixels = 8'h00;
  logic [8:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [25:0] tim;
  } pix_exp_t;

  typedef struct {
    int          due;
    logic [8:0]  xy;
    logic [3:0]  line;
  } chr_exp_t;

  pix_exp_t pix_q[$];
  chr_exp_t chr_q[$];
  pix_exp_t pe;
  chr_exp_t ce;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] pix_d1_q = 8'h00;
  logic [7:0] pix_d2_q = 8'h00;

  draw_rect_char_20x16 dut (
    .pclk             (pclk),
    .rst              (rst),
    .hcount_in        (hcount_in),
    .hsync_in         (hsync_in),
    .hblnk_in         (hblnk_in),
    .vcount_in        (vcount_in),
    .vsync_in         (vsync_in),
    .vblnk_in         (vblnk_in),
    .rgb_in           (rgb_in),
    .char_line_pixels (char_line_pixels),
    .char_xy          (char_xy),
    .char_line        (char_line),
    .hcount_out       (hcount_out),
    .hsync_out        (hsync_out),
    .hblnk_out        (hblnk_out),
    .vcount_out       (vcount_out),
    .vsync_out        (vsync_out),
    .vblnk_out        (vblnk_out),
    .rgb_out          (rgb_out)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One pixel per call; the font-ROM model answers two pixels late, like the real ROM chain.
  task automatic drive_px(input int h, input int v, input logic hs, input logic hb,
                          input logic vs, input logic vb, input logic [11:0] rgb,
                          input logic [7:0] pix, input logic [11:0] exp_rgb,
                          input logic [8:0] exp_xy, input logic [3:0] exp_line);
    pix_exp_t p;
    chr_exp_t c;
    @(posedge pclk);
    #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = rgb;
    char_line_pixels = pix_d2_q;
    pix_d2_q  = pix_d1_q;
    pix_d1_q  = pix;
    p.due = cyc + 3;
    p.rgb = exp_rgb;
    p.tim = {11'(h), hs, hb, 11'(v), vs, vb};
    c.due  = cyc + 1;
    c.xy   = exp_xy;
    c.line = exp_line;
    pix_q.push_back(p);
    chr_q.push_back(c);
  endtask

  function automatic logic [50:0] all_outputs();
    return {char_xy, char_line, hcount_out, hsync_out, hblnk_out,
            vcount_out, vsync_out, vblnk_out, rgb_out};
  endfunction

  // Monitor: compare each queued expectation on the cycle it is due.
  always @(negedge pclk) begin
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      pe = pix_q.pop_front();
      if (pe.due == cyc) begin
        check("rgb_out", 64'(rgb_out), 64'(pe.rgb));
        check("timing_out",
              64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
              64'(pe.tim));
      end else begin
        check("pix_sched", 64'(cyc), 64'(pe.due));
      end
    end
    while (chr_q.size() > 0 && chr_q[0].due <= cyc) begin
      ce = chr_q.pop_front();
      if (ce.due == cyc) begin
        check("char_xy", 64'(char_xy), 64'(ce.xy));
        check("char_line", 64'(char_line), 64'(ce.line));
      end else begin
        check("chr_sched", 64'(cyc), 64'(ce.due));
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_state", 64'(all_outputs()), 64'd0);
    @(posedge pclk);
    #1 rst = 1'b0;

    // Left of the text area: pure pass-through, no address.
    for (int h = 0; h < XPOS; h++) begin
      drive_px(h, YPOS + 5, (h < 8), 1'b0, 1'b0, 1'b0, 12'h0a5, 8'hff,
               12'h0a5, 9'd0, 4'd0);
    end

    // Addressing: col 2, row 2, line 5, glyph column 5 -> pixel bit 2.
    drive_px(XPOS + 21, YPOS + 37, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a5, 8'b0000_0100,
             12'hfff, 9'b0010_00010, 4'd5);

    // Glyph 1000_0001 over the first cell of text row 1, line 1.
    for (int o = 0; o < 8; o++) begin
      drive_px(XPOS + o, YPOS + 17, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'b1000_0001,
               (o == 0 || o == 7) ? 12'hfff : 12'h123, 9'h020, 4'd1);
    end

    // Area edges.
    drive_px(XPOS + 159, YPOS + 255, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3c3, 8'h01,
             12'hfff, 9'h1f3, 4'd15);
    drive_px(XPOS + 160, YPOS + 255, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3c3, 8'hff,
             12'h3c3, 9'd0, 4'd0);
    drive_px(XPOS + 10, YPOS + 256, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 8'hff,
             12'h456, 9'd0, 4'd0);
    drive_px(XPOS - 1, YPOS + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 8'hff,
             12'h789, 9'd0, 4'd0);

    // Blanking suppresses the glyph but keeps the address.
    for (int o = 3; o < 6; o++) begin
      drive_px(XPOS + o, YPOS + 3, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0f0, 8'hff,
               12'h0f0, 9'd0, 4'd3);
    end
    drive_px(XPOS + 3, YPOS + 3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0f0, 8'hff,
             12'h0f0, 9'd0, 4'd3);
    drive_px(XPOS + 4, YPOS + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0f0, 8'hff,
             12'hfff, 9'd0, 4'd3);

    // Reset in the middle of an overlay.
    for (int o = 0; o < 4; o++) begin
      drive_px(XPOS + o, YPOS + 17, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'b1000_0001,
               (o == 0) ? 12'hfff : 12'h123, 9'h020, 4'd1);
    end
    @(posedge pclk);
    #3 rst = 1'b1;
    #1;
    check("reset_midline", 64'(all_outputs()), 64'd0);
    pix_q.delete();
    chr_q.delete();
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;

    for (int o = 0; o < 8; o++) begin
      drive_px(XPOS + o, YPOS + 17, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 8'b1000_0001,
               (o == 0 || o == 7) ? 12'hfff : 12'h321, 9'h020, 4'd1);
    end

    repeat (5) @(posedge pclk);
    #1;
    check("drain", 64'(pix_q.size() + chr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
